spi_slave_if: RTL and testbench

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

---
 rtl/spi_slave_pkg.sv | 18 +
 rtl/spi_shift_reg.sv | 40 ++++
 rtl/spi_slave_if.sv | 154 +++++++++++++++
 tb/tb_spi_slave_if.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave front end: FSM state encoding and the
// two-bit command codes carried in frame bits [9:8].
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with parallel load, MSB-first serial in/out and a
// saturating count of bits shifted since the last clear or load.
module spi_shift_reg #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [W-1:0]  i_load_data,
  input  logic          i_shift,
  input  logic          i_sin,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] L_MAX = CW'(W);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_count;

  // Shift requests are ignored once W bits are in, so the count never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_count <= '0;
    end else if (i_shift && (r_count < L_MAX)) begin
      r_data  <= {r_data[W-2:0], i_sin};
      r_count <= r_count + CW'(1);
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: assembles 10-bit command frames from MOSI for the RAM
// and returns one byte of RAM read data on MISO after a read-data command.
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int RXCW = $clog2(FRAME_W + 1);
  localparam int TXCW = $clog2(DATA_W + 1);
  localparam logic [RXCW-1:0] L_RX_FULL = RXCW'(FRAME_W);
  localparam logic [RXCW-1:0] L_RX_LAST = RXCW'(FRAME_W - 1);
  localparam logic [TXCW-1:0] L_TX_FULL = TXCW'(DATA_W);

  state_t r_state;
  state_t w_next;

  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_miso;
  logic               r_rd_addr_seen;
  logic               r_tx_active;
  logic               r_tx_done;

  logic [FRAME_W-1:0] w_rx_par;
  logic [RXCW-1:0]    w_rx_count;
  logic [DATA_W-1:0]  w_tx_par;
  logic [TXCW-1:0]    w_tx_count;

  logic w_framed;
  logic w_rx_shift;
  logic w_rx_last;
  logic w_tx_load;
  logic w_tx_shift;
  logic w_tx_finish;
  logic w_unused;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (!SS_n) w_next = ST_CHK_CMD;
      ST_CHK_CMD: begin
        if (SS_n)                w_next = ST_IDLE;
        else if (!MOSI)          w_next = ST_WRITE;
        else if (r_rd_addr_seen) w_next = ST_READ_DATA;
        else                     w_next = ST_READ_ADD;
      end
      ST_WRITE, ST_READ_ADD, ST_READ_DATA: if (SS_n) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Frame bit 9 is taken in CHK_CMD, the rest in the command state that follows.
  always_comb begin
    w_framed    = 1'b0;
    w_rx_shift  = 1'b0;
    w_rx_last   = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_tx_finish = 1'b0;
    if (!SS_n && (r_state != ST_IDLE)) begin
      w_framed    = 1'b1;
      w_rx_shift  = (w_rx_count < L_RX_FULL);
      w_rx_last   = (w_rx_count == L_RX_LAST);
      w_tx_load   = (r_state == ST_READ_DATA) && (w_rx_count == L_RX_FULL) &&
                    !r_tx_done && tx_valid;
      w_tx_shift  = r_tx_active && (w_tx_count < L_TX_FULL);
      w_tx_finish = r_tx_active && (w_tx_count == L_TX_FULL);
    end
  end

  spi_shift_reg #(.W(FRAME_W)) u_rx_sr (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (!w_framed),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_rx_shift),
    .i_sin       (MOSI),
    .o_data      (w_rx_par),
    .o_count     (w_rx_count)
  );

  spi_shift_reg #(.W(DATA_W)) u_tx_sr (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (!w_framed),
    .i_load      (w_tx_load),
    .i_load_data (tx_data),
    .i_shift     (w_tx_shift),
    .i_sin       (1'b0),
    .o_data      (w_tx_par),
    .o_count     (w_tx_count)
  );

  // The shift register MSB only matters as history; the frame is captured
  // together with the 10th bit so rx_valid appears the very next cycle.
  assign w_unused = ^{w_rx_par[FRAME_W-1], w_tx_par[DATA_W-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_miso         <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_active    <= 1'b0;
      r_tx_done      <= 1'b0;
    end else begin
      r_rx_valid <= w_rx_shift && w_rx_last;
      if (w_rx_shift && w_rx_last)
        r_rx_data <= {w_rx_par[FRAME_W-2:0], MOSI};

      if (w_rx_shift && w_rx_last && (r_state == ST_READ_ADD))
        r_rd_addr_seen <= 1'b1;
      else if (w_tx_finish)
        r_rd_addr_seen <= 1'b0;

      if (!w_framed) begin
        r_tx_active <= 1'b0;
        r_tx_done   <= 1'b0;
        r_miso      <= 1'b0;
      end else if (w_tx_load) begin
        r_tx_active <= 1'b1;
        r_tx_done   <= 1'b1;
      end else if (w_tx_shift) begin
        r_miso <= w_tx_par[DATA_W-1];
      end else if (w_tx_finish) begin
        r_miso      <= 1'b0;
        r_tx_active <= 1'b0;
      end
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: table of complete frames plus hand-built
// read-back, abort and reset sequences.
module tb_spi_slave_if;
  import spi_slave_pkg::*;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_last;

  spi_slave_if #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] frame;
    logic [9:0] exp_rx;
    state_t     exp_state;
    logic       exp_seen;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one full frame and checks the rx_valid cycle.
  task automatic run_frame(input string nm, input logic [9:0] f, input logic [9:0] erx,
                           input state_t est, input logic eseen);
    int early = 0;
    int miso_hi = 0;
    SS_n = 1'b0; MOSI = 1'b0;
    tick();
    chk({nm, " chk_cmd"}, 32'(dut.r_state), 32'(ST_CHK_CMD));
    for (int i = 9; i >= 0; i--) begin
      MOSI = f[i];
      tick();
      if (MISO) miso_hi++;
      if (i > 0 && rx_valid) early++;
    end
    chk({nm, " rx_valid"}, 32'(rx_valid), 32'd1);
    chk({nm, " rx_data"}, 32'(rx_data), 32'(erx));
    chk({nm, " state"}, 32'(dut.r_state), 32'(est));
    chk({nm, " rd_addr_seen"}, 32'(dut.r_rd_addr_seen), 32'(eseen));
    chk({nm, " early_valid"}, 32'(early), 32'd0);
    chk({nm, " miso_in_frame"}, 32'(miso_hi), 32'd0);
    exp_last = erx;
  endtask

  // Extra bits beyond the 10th, then SS_n high.
  task automatic end_frame(input string nm);
    int vcnt = 0;
    int miso_hi = 0;
    for (int i = 0; i < 3; i++) begin
      MOSI = i[0];
      tick();
      if (rx_valid) vcnt++;
      if (MISO) miso_hi++;
    end
    chk({nm, " extra_bits_valid"}, 32'(vcnt), 32'd0);
    chk({nm, " extra_bits_miso"}, 32'(miso_hi), 32'd0);
    SS_n = 1'b1;
    tick();
    chk({nm, " idle"}, 32'(dut.r_state), 32'(ST_IDLE));
    chk({nm, " rx_hold"}, 32'(rx_data), 32'(exp_last));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_last = 10'h000;
  endtask

  initial begin
    logic [7:0] pat;
    int cnt;
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    exp_last = 10'h000;

    vecs[0] = '{10'b0000001010, 10'h00A, ST_WRITE,     1'b0};
    vecs[1] = '{10'b0111111111, 10'h1FF, ST_WRITE,     1'b0};
    vecs[2] = '{10'b1010101010, 10'h2AA, ST_READ_ADD,  1'b1};
    vecs[3] = '{10'b0100110011, 10'h133, ST_WRITE,     1'b1};
    vecs[4] = '{10'b1111000011, 10'h3C3, ST_READ_DATA, 1'b1};

    tick();
    tick();
    chk("reset state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("reset rx_data", 32'(rx_data), 32'h0);
    chk("reset rx_valid", 32'(rx_valid), 32'h0);
    chk("reset miso", 32'(MISO), 32'h0);
    chk("reset rd_addr_seen", 32'(dut.r_rd_addr_seen), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle hold", 32'(dut.r_state), 32'(ST_IDLE));

    for (int v = 0; v < 5; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].exp_rx,
                vecs[v].exp_state, vecs[v].exp_seen);
      tick();
      chk($sformatf("vec%0d valid_one_cycle", v), 32'(rx_valid), 32'd0);
      end_frame($sformatf("vec%0d", v));
    end

    // Read address then read data with tx_valid held high.
    do_reset();
    pat = 8'hA5;
    run_frame("rd_addr", {CMD_RD_ADDR, 8'h05}, 10'h205, ST_READ_ADD, 1'b1);
    end_frame("rd_addr");
    tx_data = 8'hA5; tx_valid = 1'b1;
    run_frame("rd_data", {CMD_RD_DATA, 8'h00}, 10'h300, ST_READ_DATA, 1'b1);
    tick();
    chk("rd_data latch_cycle miso", 32'(MISO), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rd_data miso bit%0d", 7 - k), 32'(MISO), 32'(pat[7-k]));
    end
    tick();
    chk("rd_data miso after", 32'(MISO), 32'd0);
    chk("rd_data seen cleared", 32'(dut.r_rd_addr_seen), 32'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (MISO) cnt++;
    end
    chk("rd_data tx_valid once", 32'(cnt), 32'd0);
    SS_n = 1'b1;
    tick();
    chk("rd_data idle", 32'(dut.r_state), 32'(ST_IDLE));

    // Read data without prior read address goes to READ_ADD.
    do_reset();
    run_frame("rd_no_addr", {CMD_RD_DATA, 8'h3C}, 10'h33C, ST_READ_ADD, 1'b1);
    end_frame("rd_no_addr");

    // Partial frame abort after 5 bits.
    tx_valid = 1'b0;
    SS_n = 1'b0;
    tick();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      tick();
      if (rx_valid) cnt++;
    end
    SS_n = 1'b1;
    tick();
    if (rx_valid) cnt++;
    chk("abort idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("abort no_valid", 32'(cnt), 32'd0);
    chk("abort rx_hold", 32'(rx_data), 32'(exp_last));
    chk("abort seen kept", 32'(dut.r_rd_addr_seen), 32'd1);
    run_frame("post_abort", 10'b0001011010, 10'h05A, ST_WRITE, 1'b1);
    end_frame("post_abort");

    // Abort during MISO shifting keeps rd_addr_seen.
    tx_data = 8'hA5; tx_valid = 1'b1;
    run_frame("rd_abort", {CMD_RD_DATA, 8'h81}, 10'h381, ST_READ_DATA, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rd_abort miso bit%0d", 7 - k), 32'(MISO), 32'(pat[7-k]));
    end
    SS_n = 1'b1;
    tick();
    chk("rd_abort miso", 32'(MISO), 32'd0);
    chk("rd_abort idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rd_abort seen kept", 32'(dut.r_rd_addr_seen), 32'd1);
    chk("rd_abort rx_hold", 32'(rx_data), 32'h381);

    // Reset during MISO shifting.
    run_frame("rd_rst", {CMD_RD_DATA, 8'h7E}, 10'h37E, ST_READ_DATA, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) tick();
    chk("rd_rst pre miso", 32'(MISO), 32'(pat[5]));
    rst = 1'b1;
    tick();
    chk("rd_rst miso", 32'(MISO), 32'd0);
    chk("rd_rst idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rd_rst seen", 32'(dut.r_rd_addr_seen), 32'd0);
    chk("rd_rst rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
    tick();

    // Reset mid-frame with SS_n still low.
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rst_mid idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_mid valid", 32'(rx_valid), 32'd0);
    chk("rst_mid rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0; SS_n = 1'b1;
    tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rx_valid) cnt++;
    end
    chk("rst_mid no late valid", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
